// File: rtl/ram_port_arbiter_if.sv
// Signal bundle that links the IF/LS requesters, the RAM port arbiter and RAMHelper.
// The slave modport is the arbiter side. The master modport is the requester/RAM side.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [DATA_W-1:0] if_rsp_data;

    logic              ls_req_valid;
    logic              ls_req_ready;
    logic              ls_req_we;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [DATA_W-1:0] ls_req_wmask;
    logic              ls_rsp_valid;
    logic              ls_rsp_ready;
    logic [DATA_W-1:0] ls_rsp_data;

    logic              ram_ren;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_wmask;

    modport slave (
        input  if_req_valid, if_req_addr, if_rsp_ready,
        input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        input  ram_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output ls_req_ready, ls_rsp_valid, ls_rsp_data,
        output ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wmask
    );

    modport master (
        output if_req_valid, if_req_addr, if_rsp_ready,
        output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wmask, ls_rsp_ready,
        output ram_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
        input  ram_ren, ram_raddr, ram_wen, ram_waddr, ram_wdata, ram_wmask
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single RAMHelper port between instruction fetch and load/store.
// It grants one request at a time with round-robin tie breaking and registers the response.
module ram_port_arbiter #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 64,
    parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(64'h8000_0000)
) (
    input logic               clk,
    input logic               rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RSP_IF, RSP_LS} state_t;

    state_t            state;
    logic              prio;          // 0: LS wins a tie, 1: IF wins a tie
    logic              ifRspValid;
    logic              lsRspValid;
    logic [DATA_W-1:0] ifRspData;
    logic [DATA_W-1:0] lsRspData;

    logic              grantIf;
    logic              grantLs;
    logic [ADDR_W-1:0] ifIndex;
    logic [ADDR_W-1:0] lsIndex;

    assign ifIndex = (bus.if_req_addr - RAM_BASE) >> 3;
    assign lsIndex = (bus.ls_req_addr - RAM_BASE) >> 3;

    // NOTE: both grants get a default first so this block cannot infer a latch.
    // Grants are also masked during reset so that ready and the strobes read 0 while rst is high.
    always_comb begin
        grantIf = 1'b0;
        grantLs = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.if_req_valid && bus.ls_req_valid) begin
                grantIf = prio;
                grantLs = !prio;
            end else begin
                grantIf = bus.if_req_valid;
                grantLs = bus.ls_req_valid;
            end
        end
    end

    assign bus.if_req_ready = grantIf;
    assign bus.ls_req_ready = grantLs;

    assign bus.ram_ren   = grantIf || (grantLs && !bus.ls_req_we);
    assign bus.ram_raddr = grantIf ? ifIndex : lsIndex;
    assign bus.ram_wen   = grantLs && bus.ls_req_we;
    assign bus.ram_waddr = lsIndex;
    assign bus.ram_wdata = bus.ls_req_wdata;
    assign bus.ram_wmask = bus.ls_req_wmask;

    assign bus.if_rsp_valid = ifRspValid;
    assign bus.if_rsp_data  = ifRspData;
    assign bus.ls_rsp_valid = lsRspValid;
    assign bus.ls_rsp_data  = lsRspData;

    // NOTE: all state is updated with non-blocking assignments, so every branch sees the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            ifRspValid <= 1'b0;
            lsRspValid <= 1'b0;
            ifRspData  <= '0;
            lsRspData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantIf) begin
                        ifRspData  <= bus.ram_rdata;
                        ifRspValid <= 1'b1;
                        prio       <= 1'b0;
                        state      <= RSP_IF;
                    end else if (grantLs) begin
                        // A write acknowledge carries no data.
                        lsRspData  <= bus.ls_req_we ? '0 : bus.ram_rdata;
                        lsRspValid <= 1'b1;
                        prio       <= 1'b1;
                        state      <= RSP_LS;
                    end
                end
                RSP_IF: begin
                    if (bus.if_rsp_ready) begin
                        ifRspValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RSP_LS: begin
                    if (bus.ls_rsp_ready) begin
                        lsRspValid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
